gate_arbiter: RTL and testbench
===============================

GATE_ARBITER -- requirements
Module: gate_arbiter

Interface
REQ-001 Parameter NREQ, default 4: number of requesters sharing one 2-input AND gate (2..8).
REQ-002 Port clk, input, 1: single clock; all state changes on rising edge.
REQ-003 Port rst, input, 1: reset, synchronous and active-high.
REQ-004 Port req, input, NREQ: per-requester request level; bit i means operands on a[i], b[i] are valid.
REQ-005 Port a, input, NREQ: operand A, one bit per requester.
REQ-006 Port b, input, NREQ: operand B, one bit per requester.
REQ-007 Port gnt, output, NREQ: one-hot grant (ready); a transfer occurs on an edge where req[i] and gnt[i] are both high.
REQ-008 Port rsp_valid, output, NREQ: one-hot, one-cycle response strobe to the granted requester.
REQ-009 Port rsp_y, output, 1: shared result Y = A AND B; valid only while any rsp_valid bit is high.
REQ-010 Port busy, output, 1: high in BUSY and RESP states.

Function
REQ-011 The block SHALL use a three-state FSM: IDLE, BUSY and RESP.
REQ-012 In IDLE, gnt SHALL be combinational: one-hot to the winning requester when req is nonzero, and zero when req is zero.
REQ-013 Round-robin winner: the first requester with req high, searching from ptr upward with wrap from NREQ-1 to 0.
REQ-014 On the transfer edge, the block SHALL latch the winner's a[i] and b[i] and its index into registers and enter BUSY.
REQ-015 gnt SHALL be all-zero in BUSY and RESP; requests made during these states are held and not lost (level-sensitive).
REQ-016 In BUSY, the latched operands SHALL drive a single AND gate instance.
REQ-017 On the BUSY->RESP edge, the gate output SHALL be registered into rsp_y.
REQ-018 In RESP, rsp_valid[index] SHALL be high for exactly one cycle and the FSM then returns to IDLE.
REQ-019 Latency: transfer at edge E0, then rsp_valid high in the cycle following edge E1, then IDLE after edge E2. Throughput is one operation per 3 cycles.
REQ-020 ptr SHALL update to (winner+1) mod NREQ on every transfer edge.
REQ-021 A requester that keeps req high after its grant is treated as issuing a new request and SHALL wait its round-robin turn.
REQ-022 Dropping req before a grant SHALL be legal and SHALL leave no state.
REQ-023 rsp_y SHALL hold its last value outside RESP.
REQ-024 Operand changes after the transfer edge SHALL NOT affect the result.

Reset
REQ-025 When rst is high at an edge, the block SHALL set state=IDLE, ptr=0, rsp_valid=0, rsp_y=0 and clear the latched operands and index.
REQ-026 While rst is high, gnt SHALL be forced to 0.
REQ-027 Reset asserted in BUSY or RESP SHALL discard the operation; no rsp_valid is produced for it afterwards.
REQ-028 The first arbitration after reset SHALL start the search from requester 0.

Configuration
REQ-029 Macro GATE_ARB_FIXED_PRI_EN: when defined, the winner SHALL be the lowest-index requester with req high, and ptr SHALL be absent or unused.
REQ-030 When GATE_ARB_FIXED_PRI_EN is undefined, round-robin per REQ-013 and REQ-020 SHALL apply.
REQ-031 Both builds SHALL have identical ports, FSM and latency.

Verification
REQ-032 Single request: rst, then req=0001, a=1, b=1.
- gnt=0001 in the same cycle.
- rsp_valid=0001 and rsp_y=1 two edges later.
- busy high for 2 cycles.
REQ-033 Truth table: requester 2 issues (a,b)=00, 01, 10, 11 in sequence.
- rsp_y=0, 0, 0, 1 respectively, each with rsp_valid=0100.
REQ-034 Contention: req=1111 held continuously after reset.
- Round-robin build: grants in order 0001, 0010, 0100, 1000, 0001, one every 3 cycles.
- GATE_ARB_FIXED_PRI_EN build: gnt=0001 on every grant.
REQ-035 Wrap: ptr=3 (after serving requester 2), then req=1001.
- gnt=1000, then next grant gnt=0001.
REQ-036 Reset mid-operation: grant requester 1, assert rst in BUSY for 1 cycle.
- No rsp_valid is produced.
- state returns to IDLE.
- next req=0011 grants 0001.
REQ-037 Operand stability: after the transfer edge, toggle a and b of the granted requester.
- rsp_y equals the AND of the operands captured at the transfer edge.

Source files
------------

// File: rtl/gate_arbiter.sv
// Shares one 2-input AND gate between NREQ requesters via a 3-state IDLE/BUSY/RESP FSM.
// Define GATE_ARB_FIXED_PRI_EN for lowest-index-wins arbitration instead of round-robin.
module gate_arbiter #(
    parameter int unsigned NREQ = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    input  logic [NREQ-1:0] a,
    input  logic [NREQ-1:0] b,
    output logic [NREQ-1:0] gnt,
    output logic [NREQ-1:0] rsp_valid,
    output logic            rsp_y,
    output logic            busy
);

    localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

    state_e          state_q, state_d;
    logic            op_a_q, op_a_d;
    logic            op_b_q, op_b_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic            rsp_y_q, rsp_y_d;
    logic            and_y;
    logic            win_found;
    logic [IW-1:0]   win_idx;
    logic            xfer;
`ifndef GATE_ARB_FIXED_PRI_EN
    logic [IW-1:0]   ptr_q, ptr_d;
`endif

    // Winner search: first requester with req high, starting at ptr (or 0 when fixed priority).
    always_comb begin
        int unsigned   cand;
        logic [IW-1:0] cand_idx;
        win_found = 1'b0;
        win_idx   = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
`ifdef GATE_ARB_FIXED_PRI_EN
            cand = k;
`else
            cand = (32'(ptr_q) + k) % NREQ;
`endif
            cand_idx = IW'(cand);
            if (!win_found && req[cand_idx]) begin
                win_found = 1'b1;
                win_idx   = cand_idx;
            end
        end
    end

    assign xfer  = (state_q == StIdle) && win_found && !rst;
    assign and_y = op_a_q & op_b_q;

    always_comb begin
        gnt = '0;
        if (xfer) begin
            gnt[win_idx] = 1'b1;
        end
        rsp_valid = '0;
        if (state_q == StResp) begin
            rsp_valid[idx_q] = 1'b1;
        end
    end

    assign busy  = (state_q == StBusy) || (state_q == StResp);
    assign rsp_y = rsp_y_q;

    always_comb begin
        state_d = state_q;
        op_a_d  = op_a_q;
        op_b_d  = op_b_q;
        idx_d   = idx_q;
        rsp_y_d = rsp_y_q;
`ifndef GATE_ARB_FIXED_PRI_EN
        ptr_d   = ptr_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (xfer) begin
                    op_a_d  = a[win_idx];
                    op_b_d  = b[win_idx];
                    idx_d   = win_idx;
                    state_d = StBusy;
`ifndef GATE_ARB_FIXED_PRI_EN
                    ptr_d   = (win_idx == IW'(NREQ - 1)) ? '0 : win_idx + 1'b1;
`endif
                end
            end
            StBusy: begin
                rsp_y_d = and_y;
                state_d = StResp;
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            op_a_q  <= 1'b0;
            op_b_q  <= 1'b0;
            idx_q   <= '0;
            rsp_y_q <= 1'b0;
`ifndef GATE_ARB_FIXED_PRI_EN
            ptr_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
            idx_q   <= idx_d;
            rsp_y_q <= rsp_y_d;
`ifndef GATE_ARB_FIXED_PRI_EN
            ptr_q   <= ptr_d;
`endif
        end
    end

endmodule

// File: tb/tb_gate_arbiter.sv
// Directed self-checking bench for gate_arbiter (NREQ=4); expectations follow the build macro.
module tb_gate_arbiter;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] gnt;
    logic [3:0] rsp_valid;
    logic       rsp_y;
    logic       busy;

    int total = 0;
    int bad   = 0;

    gate_arbiter #(.NREQ(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .a         (a),
        .b         (b),
        .gnt       (gnt),
        .rsp_valid (rsp_valid),
        .rsp_y     (rsp_y),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full operation: grant in IDLE, BUSY, RESP strobe, back to IDLE.
    task automatic op(input string tag, input logic [3:0] r, input logic [3:0] av,
                      input logic [3:0] bv, input logic [3:0] eg, input logic ey,
                      input bit keep, input bit tgl);
        req = r;
        a   = av;
        b   = bv;
        #1;
        chk({tag, "/gnt"}, {4'b0, gnt}, {4'b0, eg});
        chk({tag, "/busy_idle"}, {7'b0, busy}, 8'd0);
        tick();
        if (!keep) req = '0;
        if (tgl) begin
            a = ~a;
            b = ~b;
        end
        #1;
        chk({tag, "/gnt_busy"}, {4'b0, gnt}, 8'd0);
        chk({tag, "/busy_busy"}, {7'b0, busy}, 8'd1);
        chk({tag, "/rv_busy"}, {4'b0, rsp_valid}, 8'd0);
        tick();
        chk({tag, "/rv_resp"}, {4'b0, rsp_valid}, {4'b0, eg});
        chk({tag, "/y_resp"}, {7'b0, rsp_y}, {7'b0, ey});
        chk({tag, "/busy_resp"}, {7'b0, busy}, 8'd1);
        chk({tag, "/gnt_resp"}, {4'b0, gnt}, 8'd0);
        tick();
        chk({tag, "/rv_done"}, {4'b0, rsp_valid}, 8'd0);
        chk({tag, "/busy_done"}, {7'b0, busy}, 8'd0);
        chk({tag, "/y_hold"}, {7'b0, rsp_y}, {7'b0, ey});
    endtask

    initial begin
        logic [3:0] exp_c [5];
`ifdef GATE_ARB_FIXED_PRI_EN
        exp_c = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
`else
        exp_c = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
`endif
        rst = 1'b1;
        req = 4'b1111;
        a   = '0;
        b   = '0;
        tick();
        tick();
        chk("rst/gnt_forced", {4'b0, gnt}, 8'd0);
        chk("rst/busy", {7'b0, busy}, 8'd0);
        chk("rst/rsp_valid", {4'b0, rsp_valid}, 8'd0);
        chk("rst/rsp_y", {7'b0, rsp_y}, 8'd0);
        req = '0;
        rst = 1'b0;
        tick();

        // Single request.
        op("single", 4'b0001, 4'b0001, 4'b0001, 4'b0001, 1'b1, 1'b0, 1'b0);

        // Truth table on requester 2.
        op("tt00", 4'b0100, 4'b0000, 4'b0000, 4'b0100, 1'b0, 1'b0, 1'b0);
        op("tt01", 4'b0100, 4'b0000, 4'b0100, 4'b0100, 1'b0, 1'b0, 1'b0);
        op("tt10", 4'b0100, 4'b0100, 4'b0000, 4'b0100, 1'b0, 1'b0, 1'b0);
        op("tt11", 4'b0100, 4'b0100, 4'b0100, 4'b0100, 1'b1, 1'b0, 1'b0);

        // Wrap: round-robin pointer sits at 3 after serving requester 2.
`ifdef GATE_ARB_FIXED_PRI_EN
        op("wrap1", 4'b1001, 4'b1000, 4'b1000, 4'b0001, 1'b0, 1'b0, 1'b0);
`else
        op("wrap1", 4'b1001, 4'b1000, 4'b1000, 4'b1000, 1'b1, 1'b0, 1'b0);
`endif
        op("wrap2", 4'b1001, 4'b0001, 4'b0000, 4'b0001, 1'b0, 1'b0, 1'b0);

        // Dropping a request before any edge leaves no state.
        req = 4'b0010;
        #1;
        chk("drop/gnt", {4'b0, gnt}, 8'b0000_0010);
        req = '0;
        tick();
        chk("drop/busy", {7'b0, busy}, 8'd0);
        tick();
        chk("drop/rsp_valid", {4'b0, rsp_valid}, 8'd0);

        // Contention after reset, req held continuously.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            op($sformatf("cont%0d", i), 4'b1111, 4'b1111, 4'(i & 1) * 4'b1111, exp_c[i],
               1'(i & 1), 1'b1, 1'b0);
        end

        // Reset during BUSY drops the operation; next arbitration restarts at 0.
        req = 4'b0010;
        a   = 4'b0010;
        b   = 4'b0010;
        #1;
        chk("midrst/gnt", {4'b0, gnt}, 8'b0000_0010);
        tick();
        req = '0;
        chk("midrst/busy", {7'b0, busy}, 8'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst/idle", {7'b0, busy}, 8'd0);
        chk("midrst/rv0", {4'b0, rsp_valid}, 8'd0);
        tick();
        chk("midrst/rv1", {4'b0, rsp_valid}, 8'd0);
        chk("midrst/y", {7'b0, rsp_y}, 8'd0);
        tick();
        chk("midrst/rv2", {4'b0, rsp_valid}, 8'd0);
        op("postrst", 4'b0011, 4'b0001, 4'b0001, 4'b0001, 1'b1, 1'b0, 1'b0);

        // Operand toggles after the transfer edge must not reach the result.
        op("stab11", 4'b0100, 4'b0100, 4'b0100, 4'b0100, 1'b1, 1'b0, 1'b1);
        op("stab00", 4'b0100, 4'b0000, 4'b0000, 4'b0100, 1'b0, 1'b0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
